// File: rtl/data_path_pkg.sv
// data_path_pkg: shared definitions for the data path slice.
//   DATA_W       : word width of the bus and general registers.
//   OP_*         : 5-bit ALU operation codes decoded from opcode[4:0].
package data_path_pkg;

  localparam int DATA_W = 32;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_OR   = 5'h03;
  localparam logic [4:0] OP_NOT  = 5'h04;
  localparam logic [4:0] OP_MUL  = 5'h05;
  localparam logic [4:0] OP_DIV  = 5'h06;
  localparam logic [4:0] OP_ROL  = 5'h07;
  localparam logic [4:0] OP_ROR  = 5'h08;
  localparam logic [4:0] OP_SHR  = 5'h09;
  localparam logic [4:0] OP_SHRA = 5'h0A;
  localparam logic [4:0] OP_SHL  = 5'h0B;
  localparam logic [4:0] OP_NEG  = 5'h0C;

endpackage

// File: rtl/data_path_if.sv
// data_path_if: control and observation bundle of the data path.
//   master : drives load enables, bus selects, ALU controls and memory data-in;
//            observes the bus and register contents.
//   slave  : the data path itself.
interface data_path_if;
  import data_path_pkg::*;

  logic e_R1, e_R2, e_R3, e_R4, e_R5;
  logic e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO;
  logic s_PC, s_Zlow, s_MDR, s_R2, s_R3, s_R4, s_R5;
  logic w_IncPC, w_read, e_alu;
  logic [5:0] opcode;
  logic [DATA_W-1:0] w_Mdatain;

  logic [DATA_W-1:0] o_bus;
  logic [DATA_W-1:0] o_R1, o_R2, o_R3, o_PC, o_MAR, o_IR, o_HI, o_LO;
  logic [DATA_W-1:0] o_Zhi, o_Zlo;

  modport master (
    output e_R1, e_R2, e_R3, e_R4, e_R5,
    output e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO,
    output s_PC, s_Zlow, s_MDR, s_R2, s_R3, s_R4, s_R5,
    output w_IncPC, w_read, e_alu, opcode, w_Mdatain,
    input  o_bus, o_R1, o_R2, o_R3, o_PC, o_MAR, o_IR, o_HI, o_LO, o_Zhi, o_Zlo
  );

  modport slave (
    input  e_R1, e_R2, e_R3, e_R4, e_R5,
    input  e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO,
    input  s_PC, s_Zlow, s_MDR, s_R2, s_R3, s_R4, s_R5,
    input  w_IncPC, w_read, e_alu, opcode, w_Mdatain,
    output o_bus, o_R1, o_R2, o_R3, o_PC, o_MAR, o_IR, o_HI, o_LO, o_Zhi, o_Zlo
  );

endinterface

// File: rtl/data_path_alu.sv
// alu: combinational ALU of the data path.
//   A      : first operand (Y register).
//   B      : second operand (bus); B[4:0] is the shift/rotate amount.
//   op     : operation code (OP_* from data_path_pkg).
//   enable : when low, result passes B through.
//   inc    : when high, result is B+1 regardless of op/enable.
//   result : 64-bit result, loaded into Z by the data path.
module alu
  import data_path_pkg::*;
(
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  input  logic [4:0]          op,
  input  logic                enable,
  input  logic                inc,
  output logic [2*DATA_W-1:0] result
);

  logic signed [DATA_W-1:0]   a_s, b_s;
  logic signed [2*DATA_W-1:0] a_w, b_w, prod_s;
  logic [2*DATA_W-1:0]        rot_l, rot_r;
  logic [4:0]                 sh;

  assign a_s = A;
  assign b_s = B;
  assign a_w = a_s;
  assign b_w = b_s;
  assign prod_s = a_w * b_w;
  assign sh = B[4:0];

  // Rotates come from shifting a doubled copy of A.
  assign rot_l = {A, A} << sh;
  assign rot_r = {A, A} >> sh;

  // Signed divide packed as {remainder, quotient}. Divide-by-zero yields an
  // all-ones quotient and the dividend as remainder; the one overflowing case
  // (most-negative / -1) wraps to the dividend with zero remainder.
  function automatic logic [2*DATA_W-1:0] div_fn(input logic signed [DATA_W-1:0] a,
                                                 input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] q, r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (a == {1'b1, {(DATA_W-1){1'b0}}} && b == '1) begin
      q = a;
      r = '0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [2*DATA_W-1:0] zext(input logic [DATA_W-1:0] x);
    return {{DATA_W{1'b0}}, x};
  endfunction

  always_comb begin
    result = '0;
    if (inc) begin
      result = zext(B + {{(DATA_W-1){1'b0}}, 1'b1});
    end else if (!enable) begin
      result = zext(B);
    end else begin
      case (op)
        OP_ADD:  result = zext(A + B);
        OP_SUB:  result = zext(A - B);
        OP_AND:  result = zext(A & B);
        OP_OR:   result = zext(A | B);
        OP_NOT:  result = zext(~B);
        OP_MUL:  result = prod_s;
        OP_DIV:  result = div_fn(a_s, b_s);
        OP_ROL:  result = zext(rot_l[2*DATA_W-1:DATA_W]);
        OP_ROR:  result = zext(rot_r[DATA_W-1:0]);
        OP_SHR:  result = zext(A >> sh);
        OP_SHRA: result = zext($unsigned(a_s >>> sh));
        OP_SHL:  result = zext(A << sh);
        OP_NEG:  result = zext({DATA_W{1'b0}} - B);
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/data_path.sv
// data_path: single-bus register file, MDR input mux, Z register and ALU.
//   w_clock : clock, all state changes on its rising edge.
//   w_clear : synchronous active-low clear of every register.
//   dp      : control/observation bundle (load enables, bus selects, ALU
//             controls, memory data-in, bus and register outputs).
module data_path
  import data_path_pkg::*;
(
  input logic       w_clock,
  input logic       w_clear,
  data_path_if.slave dp
);

  logic [DATA_W-1:0]   r1, r2, r3, r4, r5;
  logic [DATA_W-1:0]   pc, mar, mdr, ir, y, hi, lo;
  logic [2*DATA_W-1:0] z;
  logic [DATA_W-1:0]   bus;
  logic [2*DATA_W-1:0] alu_result;
  logic                unused_opcode_msb;

  assign unused_opcode_msb = dp.opcode[5];

  // Bus source mux, fixed priority; nothing selected drives zero.
  always_comb begin
    bus = '0;
    if      (dp.s_PC)   bus = pc;
    else if (dp.s_Zlow) bus = z[DATA_W-1:0];
    else if (dp.s_MDR)  bus = mdr;
    else if (dp.s_R2)   bus = r2;
    else if (dp.s_R3)   bus = r3;
    else if (dp.s_R4)   bus = r4;
    else if (dp.s_R5)   bus = r5;
  end

  alu u_alu (
    .A      (y),
    .B      (bus),
    .op     (dp.opcode[4:0]),
    .enable (dp.e_alu),
    .inc    (dp.w_IncPC),
    .result (alu_result)
  );

  always_ff @(posedge w_clock) begin
    if (!w_clear) begin
      r1  <= '0;
      r2  <= '0;
      r3  <= '0;
      r4  <= '0;
      r5  <= '0;
      pc  <= '0;
      mar <= '0;
      mdr <= '0;
      ir  <= '0;
      y   <= '0;
      hi  <= '0;
      lo  <= '0;
      z   <= '0;
    end else begin
      if (dp.e_R1)  r1  <= bus;
      if (dp.e_R2)  r2  <= bus;
      if (dp.e_R3)  r3  <= bus;
      if (dp.e_R4)  r4  <= bus;
      if (dp.e_R5)  r5  <= bus;
      if (dp.e_PC)  pc  <= bus;
      if (dp.e_MAR) mar <= bus;
      if (dp.e_IR)  ir  <= bus;
      if (dp.e_Y)   y   <= bus;
      if (dp.e_HI)  hi  <= bus;
      if (dp.e_LO)  lo  <= bus;
      if (dp.e_MDR) mdr <= dp.w_read ? dp.w_Mdatain : bus;
      if (dp.e_Z)   z   <= alu_result;
    end
  end

  assign dp.o_bus = bus;
  assign dp.o_R1  = r1;
  assign dp.o_R2  = r2;
  assign dp.o_R3  = r3;
  assign dp.o_PC  = pc;
  assign dp.o_MAR = mar;
  assign dp.o_IR  = ir;
  assign dp.o_HI  = hi;
  assign dp.o_LO  = lo;
  assign dp.o_Zhi = z[2*DATA_W-1:DATA_W];
  assign dp.o_Zlo = z[DATA_W-1:0];

endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed and randomized checks of data_path against a
// behavioural model of the ALU rules.
module tb_data_path;

  logic w_clock;
  logic w_clear;
  int   checks;
  int   errors;

  data_path_if dif ();

  data_path dut (
    .w_clock (w_clock),
    .w_clear (w_clear),
    .dp      (dif)
  );

  initial w_clock = 1'b0;
  always #5 w_clock = ~w_clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {dif.e_R1, dif.e_R2, dif.e_R3, dif.e_R4, dif.e_R5} = '0;
    {dif.e_MAR, dif.e_Z, dif.e_PC, dif.e_MDR, dif.e_IR, dif.e_Y, dif.e_HI, dif.e_LO} = '0;
    {dif.s_PC, dif.s_Zlow, dif.s_MDR, dif.s_R2, dif.s_R3, dif.s_R4, dif.s_R5} = '0;
    dif.w_IncPC = 1'b0;
    dif.w_read  = 1'b0;
    dif.e_alu   = 1'b0;
    dif.opcode  = '0;
    dif.w_Mdatain = '0;
  endtask

  // One clock: inputs set beforehand take effect on this edge, then go idle.
  task automatic cyc();
    @(posedge w_clock);
    #1;
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    dif.w_Mdatain = v;
    dif.w_read = 1'b1;
    dif.e_MDR = 1'b1;
    cyc();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".bus"}, 64'(dif.o_bus), 64'h0);
    check({tag, ".R1"},  64'(dif.o_R1),  64'h0);
    check({tag, ".R2"},  64'(dif.o_R2),  64'h0);
    check({tag, ".R3"},  64'(dif.o_R3),  64'h0);
    check({tag, ".PC"},  64'(dif.o_PC),  64'h0);
    check({tag, ".MAR"}, 64'(dif.o_MAR), 64'h0);
    check({tag, ".IR"},  64'(dif.o_IR),  64'h0);
    check({tag, ".HI"},  64'(dif.o_HI),  64'h0);
    check({tag, ".LO"},  64'(dif.o_LO),  64'h0);
    check({tag, ".Zhi"}, 64'(dif.o_Zhi), 64'h0);
    check({tag, ".Zlo"}, 64'(dif.o_Zlo), 64'h0);
  endtask

  // Behavioural ALU: plain integer arithmetic and bit-at-a-time shifting.
  function automatic logic [63:0] ref_alu(input bit inc, input bit en, input logic [5:0] opc,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [31:0] x;
    int n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = int'(b[4:0]);
    x  = a;
    if (inc) return {32'h0, b + 32'd1};
    if (!en) return {32'h0, b};
    case (int'(opc[4:0]))
      0:  return {32'h0, a + b};
      1:  return {32'h0, a - b};
      2:  return {32'h0, a & b};
      3:  return {32'h0, a | b};
      4:  return {32'h0, ~b};
      5: begin
        p = sa * sb;
        return p;
      end
      6: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      7:  begin for (int i = 0; i < n; i++) x = {x[30:0], x[31]}; return {32'h0, x}; end
      8:  begin for (int i = 0; i < n; i++) x = {x[0], x[31:1]};  return {32'h0, x}; end
      9:  begin for (int i = 0; i < n; i++) x = {1'b0, x[31:1]};  return {32'h0, x}; end
      10: begin for (int i = 0; i < n; i++) x = {x[31], x[31:1]}; return {32'h0, x}; end
      11: begin for (int i = 0; i < n; i++) x = {x[30:0], 1'b0};  return {32'h0, x}; end
      12: return {32'h0, 32'h0 - b};
      default: return 64'h0;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b;
    logic [5:0]  opc;
    bit          inc, en;
    logic [63:0] exp;

    checks = 0;
    errors = 0;
    idle();

    // Reset held for two cycles.
    w_clear = 1'b0;
    cyc();
    cyc();
    check_all_zero("reset");
    w_clear = 1'b1;

    // shl sequence.
    load_mdr(32'h12);
    dif.s_MDR = 1'b1; dif.e_R2 = 1'b1; cyc();
    check("shl.R2", 64'(dif.o_R2), 64'h12);
    load_mdr(32'h2);
    dif.s_MDR = 1'b1; dif.e_R3 = 1'b1; cyc();
    check("shl.R3", 64'(dif.o_R3), 64'h2);
    dif.s_R2 = 1'b1; dif.e_Y = 1'b1; cyc();
    dif.s_R3 = 1'b1; dif.opcode = 6'h0B; dif.e_alu = 1'b1; dif.e_Z = 1'b1; cyc();
    check("shl.Zlo", 64'(dif.o_Zlo), 64'h48);
    dif.s_Zlow = 1'b1; dif.e_R1 = 1'b1; dif.e_LO = 1'b1; cyc();
    check("shl.R1", 64'(dif.o_R1), 64'h48);
    check("shl.LO", 64'(dif.o_LO), 64'h48);

    // Fetch.
    dif.s_PC = 1'b1; dif.e_MAR = 1'b1; dif.w_IncPC = 1'b1; dif.e_Z = 1'b1; cyc();
    check("fetch.MAR", 64'(dif.o_MAR), 64'h0);
    check("fetch.Zlo", 64'(dif.o_Zlo), 64'h1);
    check("fetch.Zhi", 64'(dif.o_Zhi), 64'h0);
    dif.s_Zlow = 1'b1; dif.e_PC = 1'b1; cyc();
    check("fetch.PC", 64'(dif.o_PC), 64'h1);
    load_mdr(32'h28918000);
    dif.s_MDR = 1'b1; dif.e_IR = 1'b1; cyc();
    check("fetch.IR", 64'(dif.o_IR), 64'h28918000);

    // Bus priority and idle bus.
    dif.s_PC = 1'b1; dif.s_MDR = 1'b1; #1;
    check("bus.prio", 64'(dif.o_bus), 64'h1);
    idle(); #1;
    check("bus.none", 64'(dif.o_bus), 64'h0);

    // Simultaneous loads from one bus value.
    dif.s_MDR = 1'b1; dif.e_R1 = 1'b1; dif.e_R2 = 1'b1; dif.e_HI = 1'b1;
    dif.e_MAR = 1'b1; dif.e_PC = 1'b1; cyc();
    check("multi.R1",  64'(dif.o_R1),  64'h28918000);
    check("multi.R2",  64'(dif.o_R2),  64'h28918000);
    check("multi.HI",  64'(dif.o_HI),  64'h28918000);
    check("multi.MAR", 64'(dif.o_MAR), 64'h28918000);
    check("multi.PC",  64'(dif.o_PC),  64'h28918000);

    // mul: -1 * 2.
    load_mdr(32'hFFFFFFFF);
    dif.s_MDR = 1'b1; dif.e_Y = 1'b1; cyc();
    load_mdr(32'h2);
    dif.s_MDR = 1'b1; dif.e_R2 = 1'b1; cyc();
    dif.s_R2 = 1'b1; dif.opcode = 6'h05; dif.e_alu = 1'b1; dif.e_Z = 1'b1; cyc();
    check("mul.Zhi", 64'(dif.o_Zhi), 64'hFFFFFFFF);
    check("mul.Zlo", 64'(dif.o_Zlo), 64'hFFFFFFFE);

    // div: 0x12 / 4 and 0x12 / 0.
    load_mdr(32'h12);
    dif.s_MDR = 1'b1; dif.e_Y = 1'b1; cyc();
    load_mdr(32'h4);
    dif.s_MDR = 1'b1; dif.e_R2 = 1'b1; cyc();
    dif.s_R2 = 1'b1; dif.opcode = 6'h06; dif.e_alu = 1'b1; dif.e_Z = 1'b1; cyc();
    check("div.Zlo", 64'(dif.o_Zlo), 64'h4);
    check("div.Zhi", 64'(dif.o_Zhi), 64'h2);
    dif.opcode = 6'h06; dif.e_alu = 1'b1; dif.e_Z = 1'b1; cyc();
    check("div0.Zlo", 64'(dif.o_Zlo), 64'hFFFFFFFF);
    check("div0.Zhi", 64'(dif.o_Zhi), 64'h12);

    // shra 0x80000000 by 4.
    load_mdr(32'h80000000);
    dif.s_MDR = 1'b1; dif.e_Y = 1'b1; cyc();
    load_mdr(32'h4);
    dif.s_MDR = 1'b1; dif.e_R2 = 1'b1; cyc();
    dif.s_R2 = 1'b1; dif.opcode = 6'h0A; dif.e_alu = 1'b1; dif.e_Z = 1'b1; cyc();
    check("shra.Zlo", 64'(dif.o_Zlo), 64'hF8000000);

    // MDR loads from the bus when w_read is low.
    dif.s_R2 = 1'b1; dif.e_MDR = 1'b1; cyc();
    dif.s_MDR = 1'b1; dif.e_IR = 1'b1; cyc();
    check("mdr.frombus", 64'(dif.o_IR), 64'h4);

    // Randomized ALU operations: Y <- a, R4 <- b, Z <- alu(a, bus=b).
    for (int it = 0; it < 40; it++) begin
      a   = $urandom();
      b   = $urandom();
      opc = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 15))};
      inc = ($urandom_range(0, 7) == 0);
      en  = ($urandom_range(0, 7) != 0);
      if (opc[4:0] == 5'h06 && $urandom_range(0, 3) == 0) b = 32'h0;
      load_mdr(a);
      dif.s_MDR = 1'b1; dif.e_Y = 1'b1; cyc();
      load_mdr(b);
      dif.s_MDR = 1'b1; dif.e_R4 = 1'b1; cyc();
      dif.s_R4 = 1'b1; dif.opcode = opc; dif.e_alu = en; dif.w_IncPC = inc; dif.e_Z = 1'b1;
      #1;
      check("rand.bus", 64'(dif.o_bus), 64'(b));
      cyc();
      exp = ref_alu(inc, en, opc, a, b);
      check($sformatf("rand.Z op=%h inc=%0d en=%0d", opc, inc, en),
            {dif.o_Zhi, dif.o_Zlo}, exp);
    end

    // Reset mid-sequence overrides enables and clears everything.
    load_mdr(32'hA5A5A5A5);
    dif.s_MDR = 1'b1; dif.e_R1 = 1'b1; dif.e_PC = 1'b1; dif.e_LO = 1'b1; cyc();
    check("pre.R1", 64'(dif.o_R1), 64'hA5A5A5A5);
    dif.s_MDR = 1'b1; dif.e_R1 = 1'b1; dif.e_R3 = 1'b1; dif.e_Z = 1'b1; dif.e_IR = 1'b1;
    w_clear = 1'b0;
    cyc();
    check_all_zero("midreset");
    w_clear = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound the run in case the clock or sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
